sram_dp_clr: RTL and testbench

//   Parametrised simple dual-port SRAM: one write port and one read port on a single clock.
//   - Width and depth are parameters.
//   - Writes are byte-granular, using byte enables.
//   - Reads are registered, with a valid flag.
//   - Read-during-write to the same address is selectable.
//   - A built-in clear engine fills the array with INIT_VAL after reset and on request.

---
 rtl/sram_dp_clr.sv | 125 ++++++++++++
 tb/tb_sram_dp_clr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_clr.sv
// Simple dual-port SRAM with byte-enable writes and a registered read port.
// A built-in clear engine fills the array with INIT_VAL after reset and on request.
module sram_dp_clr #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 4,
    parameter bit                RDW_MODE = 1'b0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    // state | meaning
    // CLEAR | clear engine writes INIT_VAL to mem[clr_addr]; user access ignored
    // IDLE  | user reads and writes serviced; clr_req starts a new clear

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    generate
        if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
            $error("sram_dp_clr: DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   next_clr_addr;
    logic                clr_we;
    logic                user_we;
    logic                user_re;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= next_state;
            clr_addr <= next_clr_addr;
        end
    end

    always_comb begin
        next_state    = state;
        next_clr_addr = clr_addr;
        busy          = 1'b0;
        clr_we        = 1'b0;
        case (state)
            CLEAR: begin
                busy          = 1'b1;
                clr_we        = 1'b1;
                next_clr_addr = clr_addr + 1'b1;
                if (&clr_addr) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    next_state    = CLEAR;
                    next_clr_addr = '0;
                end
            end
            default: begin
                next_state    = CLEAR;
                next_clr_addr = '0;
            end
        endcase
    end

    assign user_we = (state == IDLE) && we;
    assign user_re = (state == IDLE) && re;

    // Merged word is also the RDW_MODE=1 collision result, so both paths share it.
    always_comb begin
        wr_word = mem[waddr];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                wr_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (user_we) begin
            mem[waddr] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= user_re;
            if (user_re) begin
                if (RDW_MODE && user_we && (waddr == raddr)) begin
                    rdata <= wr_word;
                end else begin
                    rdata <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_dp_clr.sv
// Bench for sram_dp_clr: an 8-bit old-data instance and a 16-bit new-data instance
// driven in lockstep, checked through a scoreboard queue fed by tables and a model.
module tb_sram_dp_clr;

    localparam logic [15:0] INIT_B = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  waddr = '0;
    logic [3:0]  raddr = '0;
    logic [1:0]  wbe = '0;
    logic [15:0] wdata = '0;

    logic        busy_a, busy_b, rvalid_a, rvalid_b;
    logic [7:0]  rdata_a;
    logic [15:0] rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_dp_clr #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1'b0), .INIT_VAL(8'h00)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .we(we), .waddr(waddr), .wbe(wbe[0:0]), .wdata(wdata[7:0]),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
    );

    sram_dp_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1'b1), .INIT_VAL(INIT_B)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    typedef struct {
        logic        busy;
        logic        rv;
        logic [7:0]  a;
        logic [15:0] b;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [1:0]  wbe;
        logic [15:0] wdata;
        logic        re;
        logic [3:0]  raddr;
        logic        rv;
        logic [7:0]  a;
        logic [15:0] b;
    } vec_t;

    exp_t sb[$];
    vec_t tab[14];

    logic [7:0]  ma [16];
    logic [15:0] mb [16];
    logic        m_busy, m_rv;
    logic [3:0]  m_caddr;
    logic [7:0]  m_a;
    logic [15:0] m_b;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b1;
        m_caddr = '0;
        m_rv    = 1'b0;
        m_a     = '0;
        m_b     = '0;
    endtask

    task automatic model_step();
        logic [7:0]  na;
        logic [15:0] nb;
        if (m_busy) begin
            ma[m_caddr] = 8'h00;
            mb[m_caddr] = INIT_B;
            m_rv = 1'b0;
            if (m_caddr == 4'd15) m_busy = 1'b0;
            m_caddr = m_caddr + 4'd1;
        end else begin
            na = ma[waddr];
            nb = mb[waddr];
            if (wbe[0]) begin
                na = wdata[7:0];
                nb[7:0] = wdata[7:0];
            end
            if (wbe[1]) nb[15:8] = wdata[15:8];
            m_rv = re;
            if (re) begin
                m_a = ma[raddr];
                m_b = (we && waddr == raddr) ? nb : mb[raddr];
            end
            if (we) begin
                ma[waddr] = na;
                mb[waddr] = nb;
            end
            if (clr_req) begin
                m_busy  = 1'b1;
                m_caddr = '0;
            end
        end
    endtask

    // One clock: expected result queued at drive time, compared just after the edge.
    task automatic cyc(input bit use_tab, input exp_t e, input string nm);
        exp_t got;
        model_step();
        if (use_tab) sb.push_back(e);
        else sb.push_back('{busy: m_busy, rv: m_rv, a: m_a, b: m_b});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
        end else begin
            got = sb.pop_front();
            check({nm, ".busy_a"}, {15'd0, busy_a}, {15'd0, got.busy});
            check({nm, ".busy_b"}, {15'd0, busy_b}, {15'd0, got.busy});
            check({nm, ".rvalid_a"}, {15'd0, rvalid_a}, {15'd0, got.rv});
            check({nm, ".rvalid_b"}, {15'd0, rvalid_b}, {15'd0, got.rv});
            check({nm, ".rdata_a"}, {8'd0, rdata_a}, {8'd0, got.a});
            check({nm, ".rdata_b"}, rdata_b, got.b);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr_req = 1'b0; wbe = '0;
    endtask

    task automatic busy_run(input logic [7:0] ha, input logic [15:0] hb, input bool_poke, input string nm);
        for (int i = 0; i < 16; i++) begin
            we = bool_poke; re = bool_poke;
            waddr = 4'($urandom_range(0, 15)); raddr = 4'($urandom_range(0, 15));
            wbe = 2'b11; wdata = 16'($urandom);
            clr_req = bool_poke && (i == 5);
            cyc(1'b1, '{busy: (i < 15), rv: 1'b0, a: ha, b: hb}, nm);
        end
        idle_inputs();
    endtask

    task automatic read_all_init(input string nm);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = 4'(i);
            cyc(1'b1, '{busy: 1'b0, rv: 1'b1, a: 8'h00, b: INIT_B}, nm);
        end
        idle_inputs();
        cyc(1'b1, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: INIT_B}, {nm, "_hold"});
    endtask

    initial begin
        tab[0]  = '{1'b1, 4'd3, 2'b11, 16'h00A5, 1'b0, 4'd0, 1'b0, 8'h00, 16'h5A5A};
        tab[1]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 1'b1, 8'hA5, 16'h00A5};
        tab[2]  = '{1'b1, 4'd5, 2'b11, 16'h1234, 1'b0, 4'd0, 1'b0, 8'hA5, 16'h00A5};
        tab[3]  = '{1'b1, 4'd5, 2'b01, 16'hABCD, 1'b0, 4'd0, 1'b0, 8'hA5, 16'h00A5};
        tab[4]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 1'b1, 8'hCD, 16'h12CD};
        tab[5]  = '{1'b1, 4'd7, 2'b11, 16'h0011, 1'b0, 4'd0, 1'b0, 8'hCD, 16'h12CD};
        tab[6]  = '{1'b1, 4'd7, 2'b11, 16'h0022, 1'b1, 4'd7, 1'b1, 8'h11, 16'h0022};
        tab[7]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 1'b1, 8'h22, 16'h0022};
        tab[8]  = '{1'b1, 4'd7, 2'b10, 16'h3344, 1'b1, 4'd7, 1'b1, 8'h22, 16'h3322};
        tab[9]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 1'b1, 8'h22, 16'h3322};
        tab[10] = '{1'b1, 4'd9, 2'b00, 16'hFFFF, 1'b1, 4'd9, 1'b1, 8'h00, 16'h5A5A};
        tab[11] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd9, 1'b1, 8'h00, 16'h5A5A};
        tab[12] = '{1'b1, 4'd2, 2'b11, 16'hBEEF, 1'b1, 4'd3, 1'b1, 8'hA5, 16'h00A5};
        tab[13] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd2, 1'b1, 8'hEF, 16'hBEEF};

        model_reset();
        #1;
        check("rst.busy_a", {15'd0, busy_a}, 16'd1);
        check("rst.rvalid_b", {15'd0, rvalid_b}, 16'd0);
        check("rst.rdata_b", rdata_b, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        busy_run(8'h00, 16'h0000, 1'b0, "init_clear");
        read_all_init("init_read");

        for (int i = 0; i < 14; i++) begin
            we = tab[i].we; waddr = tab[i].waddr; wbe = tab[i].wbe; wdata = tab[i].wdata;
            re = tab[i].re; raddr = tab[i].raddr;
            cyc(1'b1, '{busy: 1'b0, rv: tab[i].rv, a: tab[i].a, b: tab[i].b},
                $sformatf("tab%0d", i));
        end
        idle_inputs();

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            wbe = 2'($urandom_range(0, 3)); wdata = 16'($urandom);
            cyc(1'b0, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: 16'h0000}, "rand");
        end

        for (int i = 0; i < 16; i++) begin
            we = 1'b1; re = 1'b0; waddr = 4'(i); wbe = 2'b11; wdata = 16'hC000 | 16'(i + 1);
            cyc(1'b0, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: 16'h0000}, "fill");
        end
        we = 1'b1; waddr = 4'd0; wdata = 16'h9999; re = 1'b1; raddr = 4'd3; clr_req = 1'b1;
        cyc(1'b0, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: 16'h0000}, "clr_edge");
        check("clr_edge.rdata_a", {8'd0, rdata_a}, 16'h0004);
        busy_run(8'h04, 16'hC004, 1'b1, "req_clear");
        read_all_init("req_read");

        we = 1'b1; waddr = 4'd4; wbe = 2'b11; wdata = 16'h7777; re = 1'b0;
        cyc(1'b0, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: 16'h0000}, "pre_w");
        we = 1'b0; re = 1'b1; raddr = 4'd4;
        cyc(1'b1, '{busy: 1'b0, rv: 1'b1, a: 8'h77, b: 16'h7777}, "pre_r");
        re = 1'b0; clr_req = 1'b1;
        cyc(1'b0, '{busy: 1'b0, rv: 1'b0, a: 8'h00, b: 16'h0000}, "mid_req");
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, '{busy: 1'b1, rv: 1'b0, a: 8'h77, b: 16'h7777}, "mid_clear");
        end
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst.busy_b", {15'd0, busy_b}, 16'd1);
        check("midrst.rvalid_a", {15'd0, rvalid_a}, 16'd0);
        check("midrst.rdata_a", {8'd0, rdata_a}, 16'd0);
        check("midrst.rdata_b", rdata_b, 16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        busy_run(8'h00, 16'h0000, 1'b0, "restart_clear");
        read_all_init("restart_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
